relu_backprop: RTL and testbench

Streaming ReLU gradient unit for the LeNet-5 training path; the backward-direction counterpart of the forward `relu` activation. During the forward pass it captures one sign-mask bit per pre-activation value (1 when the value is strictly positive). During the backward pass it replays those bits in capture order and gates incoming loss gradients: it passes the gradient where the mask is 1 and outputs zero elsewhere. It sits between a layer's forward `relu` tap and the gradient stream coming back from the next layer.

---
 rtl/lenet_pkg.sv | 19 +
 rtl/relu_backprop_if.sv | 28 ++
 rtl/relu_mask_mem.sv | 26 ++
 rtl/relu_backprop.sv | 159 +++++++++++++++
 tb/tb_relu_backprop.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/lenet_pkg.sv
// Shared LeNet-5 definitions: default datapath width, ReLU gradient FSM
// state type, and the single definition of "positive" used by both the
// forward relu and its backward gradient gate.
package lenet_pkg;

    localparam int BIT_WIDTH = 32;

    typedef enum logic [0:0] {
        CAPTURE = 1'b0,
        DRAIN   = 1'b1
    } relu_bp_state_t;

    // Mask is 1 only for strictly positive values; zero maps to 0, which
    // defines the ReLU gradient at the origin as 0.
    function automatic logic relu_mask_f(input logic sign_bit, input logic nonzero);
        return ~sign_bit & nonzero;
    endfunction

endpackage : lenet_pkg

// File: rtl/relu_backprop_if.sv
// Stream bundle for relu_backprop: forward pre-activation channel, gradient
// input channel and gated gradient output channel.
interface relu_backprop_if #(
    parameter int BIT_WIDTH = lenet_pkg::BIT_WIDTH
) ();

    logic                 fwd_valid;
    logic                 fwd_ready;
    logic [BIT_WIDTH-1:0] fwd_in;
    logic                 fwd_last;
    logic                 bwd_valid;
    logic                 bwd_ready;
    logic [BIT_WIDTH-1:0] bwd_grad;
    logic                 out_valid;
    logic                 out_ready;
    logic [BIT_WIDTH-1:0] out_grad;

    modport master (
        output fwd_valid, fwd_in, fwd_last, bwd_valid, bwd_grad, out_ready,
        input  fwd_ready, bwd_ready, out_valid, out_grad
    );

    modport slave (
        input  fwd_valid, fwd_in, fwd_last, bwd_valid, bwd_grad, out_ready,
        output fwd_ready, bwd_ready, out_valid, out_grad
    );

endinterface : relu_backprop_if

// File: rtl/relu_mask_mem.sv
// DEPTH x 1 sign-mask store: synchronous write, combinational read.
// Contents are intentionally not reset; every pass rewrites what it reads.
module relu_mask_mem #(
    parameter  int DEPTH  = 1024,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic              wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic              rdata_o
);

    logic [DEPTH-1:0] mem_q;

    // Capture one mask bit per accepted forward beat.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule : relu_mask_mem

// File: rtl/relu_backprop.sv
// Streaming ReLU gradient unit. CAPTURE records one mask bit per forward
// pre-activation; DRAIN replays the bits in capture order and gates the
// returning gradients through a one-deep output register.
module relu_backprop
    import lenet_pkg::relu_bp_state_t;
    import lenet_pkg::CAPTURE;
    import lenet_pkg::DRAIN;
    import lenet_pkg::relu_mask_f;
#(
    parameter  int BIT_WIDTH = lenet_pkg::BIT_WIDTH,
    parameter  int DEPTH     = 1024,
    localparam int ADDR_W    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    relu_backprop_if.slave    bus,
    output logic [ADDR_W:0]   count,
    output logic              ovf
);

    localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    relu_bp_state_t       state_q,     state_d;
    logic [ADDR_W-1:0]    wr_ptr_q,    wr_ptr_d;
    logic [ADDR_W-1:0]    rd_ptr_q,    rd_ptr_d;
    logic [ADDR_W:0]      count_q,     count_d;
    logic                 ovf_q,       ovf_d;
    logic                 out_valid_q, out_valid_d;
    logic [BIT_WIDTH-1:0] out_grad_q,  out_grad_d;

    logic                 fwd_ready_s;
    logic                 bwd_ready_s;
    logic                 fwd_fire_s;
    logic                 bwd_fire_s;
    logic                 mem_we_s;
    logic                 wr_mask_s;
    logic                 rd_mask_s;
    logic [ADDR_W:0]      count_inc_s;
    logic                 rd_last_s;

    // Ready depends on state and, for the gradient channel, on whether the
    // output register is free or being emptied this cycle.
    assign fwd_ready_s = (state_q == CAPTURE);
    assign bwd_ready_s = (state_q == DRAIN) && (!out_valid_q || bus.out_ready);
    assign fwd_fire_s  = bus.fwd_valid && fwd_ready_s;
    assign bwd_fire_s  = bus.bwd_valid && bwd_ready_s;

    assign wr_mask_s   = relu_mask_f(bus.fwd_in[BIT_WIDTH-1], |bus.fwd_in);
    assign count_inc_s = count_q + CNT_ONE;
    assign rd_last_s   = ({1'b0, rd_ptr_q} == (count_q - CNT_ONE));

    relu_mask_mem #(
        .DEPTH (DEPTH)
    ) u_mask_mem (
        .clk     (clk),
        .we_i    (mem_we_s),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_mask_s),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_mask_s)
    );

    // Next-state for FSM, pointers, count and sticky overflow.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        mem_we_s = 1'b0;
        case (state_q)
            CAPTURE: begin
                if (fwd_fire_s) begin
                    mem_we_s = 1'b1;
                    wr_ptr_d = wr_ptr_q + PTR_ONE;
                    count_d  = count_inc_s;
                    if (bus.fwd_last || (count_inc_s == DEPTH_C)) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = CAPTURE;
                    end
                    if ((count_inc_s == DEPTH_C) && !bus.fwd_last) begin
                        ovf_d = 1'b1;
                    end else begin
                        ovf_d = ovf_q;
                    end
                end else begin
                    state_d = CAPTURE;
                end
            end
            DRAIN: begin
                if (bwd_fire_s) begin
                    if (rd_last_s) begin
                        wr_ptr_d = '0;
                        rd_ptr_d = '0;
                        count_d  = '0;
                        state_d  = CAPTURE;
                    end else begin
                        rd_ptr_d = rd_ptr_q + PTR_ONE;
                        state_d  = DRAIN;
                    end
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d  = CAPTURE;
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                count_d  = '0;
            end
        endcase
    end

    // Output register: load gated gradient on accept, drop valid once taken.
    always_comb begin
        out_valid_d = out_valid_q;
        out_grad_d  = out_grad_q;
        if (bwd_fire_s) begin
            out_valid_d = 1'b1;
            out_grad_d  = rd_mask_s ? bus.bwd_grad : '0;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State register with synchronous reset; an in-flight pass is discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= CAPTURE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_grad_q  <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_grad_q  <= out_grad_d;
        end
    end

    assign bus.fwd_ready = fwd_ready_s;
    assign bus.bwd_ready = bwd_ready_s;
    assign bus.out_valid = out_valid_q;
    assign bus.out_grad  = out_grad_q;
    assign count         = count_q;
    assign ovf           = ovf_q;

endmodule : relu_backprop

// File: tb/tb_relu_backprop.sv
// Directed bench for relu_backprop: a full-depth unit (A) and a DEPTH=4
// unit (B) for the overflow case, both on one clock and reset.
module tb_relu_backprop;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    relu_backprop_if #(.BIT_WIDTH(32)) bus_a ();
    relu_backprop_if #(.BIT_WIDTH(32)) bus_b ();

    logic [10:0] count_a;
    logic        ovf_a;
    logic [2:0]  count_b;
    logic        ovf_b;

    relu_backprop #(.BIT_WIDTH(32), .DEPTH(1024)) dut_a (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus_a),
        .count (count_a),
        .ovf   (ovf_a)
    );

    relu_backprop #(.BIT_WIDTH(32), .DEPTH(4)) dut_b (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus_b),
        .count (count_b),
        .ovf   (ovf_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_drive(input logic fv, input logic [31:0] fin, input logic fl,
                           input logic bv, input logic [31:0] bg);
        bus_a.fwd_valid = fv;
        bus_a.fwd_in    = fin;
        bus_a.fwd_last  = fl;
        bus_a.bwd_valid = bv;
        bus_a.bwd_grad  = bg;
    endtask

    task automatic a_cycle(input logic fv, input logic [31:0] fin, input logic fl,
                           input logic bv, input logic [31:0] bg);
        a_drive(fv, fin, fl, bv, bg);
        tick();
    endtask

    task automatic b_cycle(input logic fv, input logic [31:0] fin, input logic fl,
                           input logic bv, input logic [31:0] bg);
        bus_b.fwd_valid = fv;
        bus_b.fwd_in    = fin;
        bus_b.fwd_last  = fl;
        bus_b.bwd_valid = bv;
        bus_b.bwd_grad  = bg;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] g2 [4];
        logic [31:0] e2 [4];
        logic [31:0] held;
        logic        stall_prev;
        int          in_i;
        int          out_i;
        int          cyc;

        g2 = '{32'd10, 32'd20, 32'd30, 32'd40};
        e2 = '{32'd10, 32'd0,  32'd0,  32'd40};

        // Reset
        rst = 1'b1;
        a_drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        bus_a.out_ready = 1'b1;
        bus_b.out_ready = 1'b1;
        bus_b.fwd_valid = 1'b0; bus_b.fwd_in = 32'd0; bus_b.fwd_last = 1'b0;
        bus_b.bwd_valid = 1'b0; bus_b.bwd_grad = 32'd0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_fwd_ready", {31'd0, bus_a.fwd_ready}, 32'd1);
        chk("rst_bwd_ready", {31'd0, bus_a.bwd_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, bus_a.out_valid}, 32'd0);
        chk("rst_out_grad",  bus_a.out_grad, 32'd0);
        chk("rst_count",     {21'd0, count_a}, 32'd0);
        chk("rst_ovf",       {31'd0, ovf_a}, 32'd0);

        // Basic pass, out_ready held high
        a_cycle(1'b1, 32'd5, 1'b0, 1'b0, 32'd0);
        chk("t1_count1", {21'd0, count_a}, 32'd1);
        a_cycle(1'b1, 32'hFFFF_FFFD, 1'b0, 1'b0, 32'd0);
        a_cycle(1'b1, 32'd0, 1'b0, 1'b0, 32'd0);
        a_cycle(1'b1, 32'h7FFF_FFFF, 1'b1, 1'b0, 32'd0);
        chk("t1_count4",    {21'd0, count_a}, 32'd4);
        chk("t1_fwd_ready", {31'd0, bus_a.fwd_ready}, 32'd0);
        chk("t1_bwd_ready", {31'd0, bus_a.bwd_ready}, 32'd1);
        a_cycle(1'b0, 32'd0, 1'b0, 1'b1, 32'd10);
        chk("t1_v0", {31'd0, bus_a.out_valid}, 32'd1);
        chk("t1_g0", bus_a.out_grad, 32'd10);
        a_cycle(1'b0, 32'd0, 1'b0, 1'b1, 32'd20);
        chk("t1_g1", bus_a.out_grad, 32'd0);
        a_cycle(1'b0, 32'd0, 1'b0, 1'b1, 32'd30);
        chk("t1_g2", bus_a.out_grad, 32'd0);
        a_cycle(1'b0, 32'd0, 1'b0, 1'b1, 32'd40);
        chk("t1_g3",        bus_a.out_grad, 32'd40);
        chk("t1_v3",        {31'd0, bus_a.out_valid}, 32'd1);
        chk("t1_end_fwdrdy", {31'd0, bus_a.fwd_ready}, 32'd1);
        chk("t1_end_count", {21'd0, count_a}, 32'd0);
        a_cycle(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        chk("t1_idle_valid", {31'd0, bus_a.out_valid}, 32'd0);

        // Same pass under backpressure: out_ready 1,0,0,1,...
        a_cycle(1'b1, 32'd5, 1'b0, 1'b0, 32'd0);
        a_cycle(1'b1, 32'hFFFF_FFFD, 1'b0, 1'b0, 32'd0);
        a_cycle(1'b1, 32'd0, 1'b0, 1'b0, 32'd0);
        a_cycle(1'b1, 32'h7FFF_FFFF, 1'b1, 1'b0, 32'd0);
        a_drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        in_i = 0; out_i = 0; cyc = 0; stall_prev = 1'b0; held = 32'd0;
        while (out_i < 4 && cyc < 40) begin
            bus_a.out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            bus_a.bwd_valid = (in_i < 4);
            bus_a.bwd_grad  = (in_i < 4) ? g2[in_i] : 32'd0;
            #1;
            if (stall_prev) chk("bp_hold", bus_a.out_grad, held);
            if (bus_a.out_valid && !bus_a.out_ready)
                chk("bp_ready_low", {31'd0, bus_a.bwd_ready}, 32'd0);
            if (bus_a.out_valid && bus_a.out_ready) begin
                chk("bp_out", bus_a.out_grad, e2[out_i]);
                out_i++;
            end
            if (bus_a.bwd_valid && bus_a.bwd_ready) in_i++;
            stall_prev = bus_a.out_valid && !bus_a.out_ready;
            held       = bus_a.out_grad;
            @(posedge clk);
            #1;
            cyc++;
        end
        bus_a.out_ready = 1'b1;
        bus_a.bwd_valid = 1'b0;
        chk("bp_outputs", out_i, 32'd4);
        chk("bp_inputs",  in_i,  32'd4);
        chk("bp_count",   {21'd0, count_a}, 32'd0);
        chk("bp_fwd_ready", {31'd0, bus_a.fwd_ready}, 32'd1);
        chk("bp_valid_clr", {31'd0, bus_a.out_valid}, 32'd0);

        // DEPTH=4 overflow on unit B
        b_cycle(1'b1, 32'd1, 1'b0, 1'b0, 32'd0);
        b_cycle(1'b1, 32'd2, 1'b0, 1'b0, 32'd0);
        b_cycle(1'b1, 32'd3, 1'b0, 1'b0, 32'd0);
        chk("ovf_pre", {31'd0, ovf_b}, 32'd0);
        b_cycle(1'b1, 32'd4, 1'b0, 1'b0, 32'd0);
        chk("ovf_set",       {31'd0, ovf_b}, 32'd1);
        chk("ovf_count",     {29'd0, count_b}, 32'd4);
        chk("ovf_fwd_ready", {31'd0, bus_b.fwd_ready}, 32'd0);
        b_cycle(1'b1, 32'd5, 1'b0, 1'b0, 32'd0);
        chk("ovf_5th_rej",   {29'd0, count_b}, 32'd4);
        b_cycle(1'b0, 32'd0, 1'b0, 1'b1, 32'd21);
        b_cycle(1'b0, 32'd0, 1'b0, 1'b1, 32'd22);
        b_cycle(1'b0, 32'd0, 1'b0, 1'b1, 32'd23);
        b_cycle(1'b0, 32'd0, 1'b0, 1'b1, 32'd24);
        chk("ovf_drain_g",   bus_b.out_grad, 32'd24);
        chk("ovf_drain_cnt", {29'd0, count_b}, 32'd0);
        chk("ovf_sticky",    {31'd0, ovf_b}, 32'd1);
        b_cycle(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);

        // Gradient offered during CAPTURE is held off until DRAIN
        a_drive(1'b0, 32'd0, 1'b0, 1'b1, 32'd99);
        #1;
        chk("cap_bwd_ready", {31'd0, bus_a.bwd_ready}, 32'd0);
        tick();
        chk("cap_no_out", {31'd0, bus_a.out_valid}, 32'd0);
        a_cycle(1'b1, 32'd7, 1'b1, 1'b1, 32'd99);
        chk("cap_not_taken", {31'd0, bus_a.out_valid}, 32'd0);
        a_cycle(1'b0, 32'd0, 1'b0, 1'b1, 32'd99);
        chk("cap_g99",   bus_a.out_grad, 32'd99);
        chk("cap_v99",   {31'd0, bus_a.out_valid}, 32'd1);
        chk("cap_count", {21'd0, count_a}, 32'd0);
        a_cycle(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);

        // Reset in the middle of DRAIN
        a_cycle(1'b1, 32'd1, 1'b0, 1'b0, 32'd0);
        a_cycle(1'b1, 32'd2, 1'b0, 1'b0, 32'd0);
        a_cycle(1'b1, 32'd3, 1'b0, 1'b0, 32'd0);
        a_cycle(1'b1, 32'd4, 1'b1, 1'b0, 32'd0);
        a_cycle(1'b0, 32'd0, 1'b0, 1'b1, 32'd11);
        a_cycle(1'b0, 32'd0, 1'b0, 1'b1, 32'd12);
        chk("mr_pre_g", bus_a.out_grad, 32'd12);
        rst = 1'b1;
        a_cycle(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        rst = 1'b0;
        chk("mr_out_valid", {31'd0, bus_a.out_valid}, 32'd0);
        chk("mr_out_grad",  bus_a.out_grad, 32'd0);
        chk("mr_count",     {21'd0, count_a}, 32'd0);
        chk("mr_fwd_ready", {31'd0, bus_a.fwd_ready}, 32'd1);
        chk("mr_bwd_ready", {31'd0, bus_a.bwd_ready}, 32'd0);
        chk("mr_ovf_b",     {31'd0, ovf_b}, 32'd0);
        a_cycle(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0);
        a_cycle(1'b1, 32'd2, 1'b1, 1'b0, 32'd0);
        a_cycle(1'b0, 32'd0, 1'b0, 1'b1, 32'd5);
        chk("mr_g0", bus_a.out_grad, 32'd0);
        a_cycle(1'b0, 32'd0, 1'b0, 1'b1, 32'd6);
        chk("mr_g1", bus_a.out_grad, 32'd6);

        // Single-element pass, then two back-to-back passes with no idle
        a_cycle(1'b1, 32'd1, 1'b1, 1'b0, 32'd0);
        a_cycle(1'b0, 32'd0, 1'b0, 1'b1, 32'hFFFF_FFF8);
        chk("se_gneg8", bus_a.out_grad, 32'hFFFF_FFF8);
        a_cycle(1'b1, 32'd3, 1'b0, 1'b0, 32'd0);
        a_cycle(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'd0);
        a_cycle(1'b0, 32'd0, 1'b0, 1'b1, 32'd100);
        chk("bb_p1_g0", bus_a.out_grad, 32'd100);
        a_cycle(1'b0, 32'd0, 1'b0, 1'b1, 32'd200);
        chk("bb_p1_g1",   bus_a.out_grad, 32'd0);
        chk("bb_fwd_rdy", {31'd0, bus_a.fwd_ready}, 32'd1);
        a_cycle(1'b1, 32'hFFFF_FFFB, 1'b0, 1'b0, 32'd0);
        a_cycle(1'b1, 32'd6, 1'b1, 1'b0, 32'd0);
        chk("bb_p2_count", {21'd0, count_a}, 32'd2);
        a_cycle(1'b0, 32'd0, 1'b0, 1'b1, 32'd300);
        chk("bb_p2_g0", bus_a.out_grad, 32'd0);
        a_cycle(1'b0, 32'd0, 1'b0, 1'b1, 32'd400);
        chk("bb_p2_g1", bus_a.out_grad, 32'd400);
        a_cycle(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        chk("bb_idle", {31'd0, bus_a.out_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_relu_backprop
